trigger_controller: RTL

TRIGGER_CONTROLLER -- requirements
Module: trigger_controller

---
 rtl/psec6_trig_pkg.sv | 16 +
 rtl/ring_ptr_counter.sv | 28 ++
 rtl/trigger_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/psec6_trig_pkg.sv
// Shared types and default sizing for the PSEC6 trigger controller.
package psec6_trig_pkg;

    // Default depth of the sampling ring and width of the post-trigger count
    localparam int NUM_SAMPLES_DEF = 256;
    localparam int DLY_W_DEF       = 8;

    // Acquisition sequence: wait for arm, wait for trigger, post-trigger fill, hold for readout
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DELAY   = 2'd2,
        ST_STOPPED = 2'd3
    } trig_state_t;

endpackage

// File: rtl/ring_ptr_counter.sv
// Write-address counter for the sampling ring; advances when enabled and
// wraps from NUM_SAMPLES-1 back to 0. Also exposes the value it would
// load next so the parent can capture the post-write address in the same edge.
module ring_ptr_counter #(
    parameter int NUM_SAMPLES = 256,
    parameter int PTR_W       = $clog2(NUM_SAMPLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] ptr_inc
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_SAMPLES - 1);

    assign ptr_inc = (ptr == LAST) ? '0 : ptr + PTR_W'(1);

    // Advance the ring address once per enabled clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (enable) begin
            ptr <= ptr_inc;
        end
    end

endmodule

// File: rtl/trigger_controller.sv
// Trigger controller for the PSEC6 sampling array. Runs the ring write
// pointer while armed, captures the pointer on a trigger rising edge,
// keeps sampling for delay_cfg more cycles, then freezes the ring and
// presents trig_ptr/stop_ptr until readout completes.
module trigger_controller
    import psec6_trig_pkg::*;
#(
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int PTR_W       = $clog2(NUM_SAMPLES),
    parameter int DLY_W       = DLY_W_DEF
) (
    input  logic             FCLK,
    input  logic             RSTB,
    input  logic             trigger_sync,
    input  logic             arm,
    input  logic             disarm,
    input  logic [DLY_W-1:0] delay_cfg,
    input  logic             rd_done,
    output logic             sample_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] trig_ptr,
    output logic [PTR_W-1:0] stop_ptr,
    output logic             data_valid,
    output logic             busy
);

    trig_state_t      state;
    trig_state_t      state_nxt;
    logic             trig_d;
    logic             trig_edge;
    logic [DLY_W-1:0] cnt;
    logic [PTR_W-1:0] ptr_inc;
    logic             fire;

    // A trigger already high when arming produces no edge, since trig_d tracks it in every state
    assign trig_edge = trigger_sync & ~trig_d;

    // Disarm beats a coincident edge
    assign fire = (state == ST_ARMED) && !disarm && trig_edge;

    ring_ptr_counter #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .PTR_W       (PTR_W)
    ) u_ring_ptr (
        .clk     (FCLK),
        .rst_n   (RSTB),
        .enable  (sample_en),
        .ptr     (wr_ptr),
        .ptr_inc (ptr_inc)
    );

    // Next-state selection for the acquisition sequence
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (disarm) begin
                    state_nxt = ST_IDLE;
                end else if (trig_edge) begin
                    state_nxt = (delay_cfg == '0) ? ST_STOPPED : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (disarm) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == DLY_W'(1)) begin
                    state_nxt = ST_STOPPED;
                end
            end
            ST_STOPPED: begin
                if (rd_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, registered status outputs, delay counter and pointer captures
    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            state      <= ST_IDLE;
            trig_d     <= 1'b0;
            cnt        <= '0;
            trig_ptr   <= '0;
            stop_ptr   <= '0;
            sample_en  <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            trig_d     <= trigger_sync;
            sample_en  <= (state_nxt == ST_ARMED) || (state_nxt == ST_DELAY);
            data_valid <= (state_nxt == ST_STOPPED);
            busy       <= (state_nxt != ST_IDLE);

            if (fire) begin
                trig_ptr <= wr_ptr;
                cnt      <= delay_cfg;
            end else if (state == ST_DELAY) begin
                cnt <= cnt - DLY_W'(1);
            end

            // Entry to STOPPED always comes from a writing cycle, so the
            // pointer lands on ptr_inc this same edge: that is the oldest sample.
            if ((state_nxt == ST_STOPPED) && (state != ST_STOPPED)) begin
                stop_ptr <= ptr_inc;
            end
        end
    end

endmodule
